// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Definitions shared by the parameterised register file and its clear
// sequencer:
//   clr_state_e        - clear sequencer states (idle, clearing, done)
//   RESET_VAL_DEFAULT  - default contents of every register after reset/clear
// ---------------------------------------------------------------------------
package regfile_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } clr_state_e;

   localparam int unsigned RESET_VAL_DEFAULT = 0;

endpackage : regfile_pkg

// File: rtl/regfile_clr_seq.sv
// ---------------------------------------------------------------------------
// regfile_clr_seq
// Walks an index over every register of the file, one register per cycle,
// so the top can overwrite each one with its reset value.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous active-low reset
//   clr_req   in   one-cycle pulse that starts a clear (ignored while busy)
//   clr_busy  out  high for the whole sequence (CLEAR and DONE)
//   clr_we    out  high while the register at clr_idx is to be cleared
//   clr_idx   out  register currently being cleared
//
// A clear occupies DEPTH cycles in CLEAR plus one in DONE, so clr_busy is
// high for DEPTH+1 cycles after the edge that accepts clr_req.
// ---------------------------------------------------------------------------
module regfile_clr_seq
   import regfile_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_idx
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   clr_state_e        state;
   clr_state_e        state_next;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_next;

   // NOTE: state is updated with non-blocking assignments so that every
   // flop samples the values from before the edge, regardless of the order
   // in which the simulator evaluates blocks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
      end
   end

   // NOTE: every output of this block gets a default first; without it any
   // path that skips an assignment would infer a latch.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      unique case (state)
         ST_IDLE: begin
            if (clr_req) begin
               state_next = ST_CLEAR;
               idx_next   = '0;
            end
         end
         ST_CLEAR: begin
            // DEPTH is a power of two, so the increment wraps back to zero
            // on the last register.
            idx_next = idx + 1'b1;
            if (idx == LAST_IDX) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            idx_next   = '0;
         end
      endcase
   end

   // A request arriving in CLEAR or DONE falls through the case above
   // untouched, which is what makes a busy sequencer ignore it.
   assign clr_busy = (state != ST_IDLE);
   assign clr_we   = (state == ST_CLEAR);
   assign clr_idx  = idx;

endmodule : regfile_clr_seq

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
// Parameterised register file: one write port, two registered read ports
// sharing a read enable, write-first bypass, optional hard-wired zero
// register, and a sequenced clear of all registers to RESET_VAL.
//
// Ports:
//   clk                  in   single clock, rising edge
//   rst_n                in   synchronous active-low reset
//   rd_en                in   captures both read ports on the edge
//   rd_addr1, rd_addr2   in   read addresses
//   rd_data1, rd_data2   out  registered read data (1-cycle latency)
//   wr_en                in   write enable
//   wr_addr              in   write address
//   wr_data              in   write data
//   clr_req              in   one-cycle pulse requesting a full clear
//   clr_busy             out  high while the clear sequence runs
// ---------------------------------------------------------------------------
module reg_file_param
   import regfile_pkg::*;
#(
   parameter int              DATA_W    = 8,
   parameter int              DEPTH     = 16,
   parameter int              ADDR_W    = $clog2(DEPTH),
   parameter int              ZERO_R0   = 0,
   parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(RESET_VAL_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_req,
   output logic              clr_busy
);

   localparam bit HAS_ZERO_R0 = (ZERO_R0 != 0);

   logic [DATA_W-1:0] regs [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_idx;
   logic              wr_fire;
   logic [DATA_W-1:0] rd_next1;
   logic [DATA_W-1:0] rd_next2;

   regfile_clr_seq #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_we   (clr_we),
      .clr_idx  (clr_idx)
   );

   // A write really happens only when no clear is running or starting, and
   // never to a hard-wired zero register. The same qualified strobe drives
   // the bypass, so a dropped write can never leak onto a read port.
   assign wr_fire = wr_en && !clr_busy && !clr_req &&
                    !(HAS_ZERO_R0 && (wr_addr == '0));

   // Storage: reset beats clear beats write.
   // NOTE: every register is reset, so this array is built from flops, not
   // an inferred RAM; that is the price of defined contents after rst_n.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= RESET_VAL;
         end
      end else if (clr_we) begin
         regs[clr_idx] <= RESET_VAL;
      end else if (wr_fire) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Read-port selection: write-first bypass, then the zero-register override
   // so address 0 reads zero even when a (discarded) write targets it.
   always_comb begin
      rd_next1 = regs[rd_addr1];
      if (wr_fire && (rd_addr1 == wr_addr)) begin
         rd_next1 = wr_data;
      end
      if (HAS_ZERO_R0 && (rd_addr1 == '0)) begin
         rd_next1 = '0;
      end
   end

   always_comb begin
      rd_next2 = regs[rd_addr2];
      if (wr_fire && (rd_addr2 == wr_addr)) begin
         rd_next2 = wr_data;
      end
      if (HAS_ZERO_R0 && (rd_addr2 == '0)) begin
         rd_next2 = '0;
      end
   end

   // Read data resets to zero (not RESET_VAL) and holds while rd_en is low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data1 <= '0;
         rd_data2 <= '0;
      end else if (rd_en) begin
         rd_data1 <= rd_next1;
         rd_data2 <= rd_next2;
      end
   end

endmodule : reg_file_param

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
// Directed bench for reg_file_param. Two instances share all inputs:
//   dut  - default parameters (ZERO_R0=0, RESET_VAL=0)
//   dutz - ZERO_R0=1, RESET_VAL=8'h5A
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam logic [DATA_W-1:0] RV_Z = 8'h5A;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr1, rd_addr2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              clr_req;

   logic [DATA_W-1:0] rd_data1, rd_data2;
   logic              clr_busy;
   logic [DATA_W-1:0] z_rd_data1, z_rd_data2;
   logic              z_clr_busy;

   int err_cnt = 0;
   int chk_cnt = 0;

   always #5 clk = ~clk;

   reg_file_param #(
      .DATA_W (DATA_W), .DEPTH (DEPTH), .ADDR_W (ADDR_W),
      .ZERO_R0 (0), .RESET_VAL (8'h00)
   ) dut (
      .clk (clk), .rst_n (rst_n), .rd_en (rd_en),
      .rd_addr1 (rd_addr1), .rd_addr2 (rd_addr2),
      .rd_data1 (rd_data1), .rd_data2 (rd_data2),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .clr_req (clr_req), .clr_busy (clr_busy)
   );

   reg_file_param #(
      .DATA_W (DATA_W), .DEPTH (DEPTH), .ADDR_W (ADDR_W),
      .ZERO_R0 (1), .RESET_VAL (RV_Z)
   ) dutz (
      .clk (clk), .rst_n (rst_n), .rd_en (rd_en),
      .rd_addr1 (rd_addr1), .rd_addr2 (rd_addr2),
      .rd_data1 (z_rd_data1), .rd_data2 (z_rd_data2),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .clr_req (clr_req), .clr_busy (z_clr_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
   endtask

   task automatic fill_all();
      for (int i = 0; i < DEPTH; i++) begin
         wr_en   = 1'b1;
         wr_addr = ADDR_W'(i);
         wr_data = 8'hC0 | DATA_W'(i);
         tick();
      end
      wr_en = 1'b0;
   endtask

   // Reads every register through both ports (low half on port 1, high half
   // on port 2) and compares with the expected cleared contents.
   task automatic check_all_cleared(input string tag);
      for (int i = 0; i < DEPTH / 2; i++) begin
         rd_en    = 1'b1;
         rd_addr1 = ADDR_W'(i);
         rd_addr2 = ADDR_W'(i + DEPTH / 2);
         tick();
         check($sformatf("%s_r%0d", tag, i), rd_data1, 8'h00);
         check($sformatf("%s_r%0d", tag, i + DEPTH / 2), rd_data2, 8'h00);
         check($sformatf("%s_z_r%0d", tag, i), z_rd_data1, (i == 0) ? 8'h00 : RV_Z);
      end
      rd_en = 1'b0;
   endtask

   initial begin
      int            n;
      logic [DATA_W-1:0] mid_val;

      rst_n = 1'b0; idle_inputs();
      rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; wr_data = '0;
      mid_val = '0;

      // Reset state
      tick(); tick();
      check("rst_rd1", rd_data1, 8'h00);
      check("rst_rd2", rd_data2, 8'h00);
      check("rst_busy", clr_busy, 1'b0);
      check("rst_z_rd1", z_rd_data1, 8'h00);
      rst_n = 1'b1;

      // Registers hold RESET_VAL after reset
      rd_en = 1'b1; rd_addr1 = 4'd3; rd_addr2 = 4'd7;
      tick();
      check("rv_rd1", rd_data1, 8'h00);
      check("rv_rd2", rd_data2, 8'h00);
      check("rv_busy", clr_busy, 1'b0);
      check("rv_z_rd1", z_rd_data1, RV_Z);
      check("rv_z_rd2", z_rd_data2, RV_Z);

      // Plain write then read, then hold while rd_en is low
      rd_en = 1'b0; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0; rd_en = 1'b1; rd_addr1 = 4'd4;
      tick();
      check("wr_rd_r4", rd_data1, 8'hA5);
      rd_en = 1'b0; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h11;
      tick();
      check("hold_r4", rd_data1, 8'hA5);
      wr_en = 1'b0; rd_en = 1'b1; rd_addr1 = 4'd4;
      tick();
      check("rd_new_r4", rd_data1, 8'h11);

      // Same-cycle bypass on both ports
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h3C;
      rd_en = 1'b1; rd_addr1 = 4'd9; rd_addr2 = 4'd9;
      tick();
      check("byp_rd1", rd_data1, 8'h3C);
      check("byp_rd2", rd_data2, 8'h3C);
      check("byp_z_rd1", z_rd_data1, 8'h3C);
      // Bypass on one port only; other port reads stored value
      wr_addr = 4'd6; wr_data = 8'h77; rd_addr1 = 4'd9; rd_addr2 = 4'd6;
      tick();
      check("byp1_rd1", rd_data1, 8'h3C);
      check("byp1_rd2", rd_data2, 8'h77);

      // Register 0: writable in dut, hard zero in dutz (incl. bypass)
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF;
      rd_en = 1'b1; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
      tick();
      check("r0_byp", rd_data1, 8'hFF);
      check("r0_z_byp1", z_rd_data1, 8'h00);
      check("r0_z_byp2", z_rd_data2, 8'h00);
      wr_en = 1'b0;
      tick();
      check("r0_rd", rd_data1, 8'hFF);
      check("r0_z_rd", z_rd_data1, 8'h00);

      // Fill, then clear with a write in the clr_req cycle
      rd_en = 1'b0;
      fill_all();
      rd_en = 1'b1; rd_addr1 = 4'd13; rd_addr2 = 4'd1;
      tick();
      check("fill_r13", rd_data1, 8'hCD);
      check("fill_z_r1", z_rd_data2, 8'hC1);

      clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h99;
      rd_en = 1'b1; rd_addr1 = 4'd2; rd_addr2 = 4'd2;
      tick();
      check("clr_wr_drop", rd_data1, 8'hC2);
      check("clr_busy_start", clr_busy, 1'b1);

      // Run the clear with writes, reads and a repeated clr_req throughout
      n = 0;
      while (clr_busy && n < 40) begin
         clr_req  = (n == 5);
         wr_en    = 1'b1; wr_addr = 4'd15; wr_data = 8'hEE;
         rd_en    = 1'b1; rd_addr1 = 4'd15;
         tick();
         n++;
         if (n == 3) mid_val = rd_data1;
      end
      idle_inputs();
      check("clr_busy_len", n, DEPTH + 1);
      check("clr_mid_read", mid_val, 8'hCF);
      check("clr_z_busy", z_clr_busy, 1'b0);
      check_all_cleared("clr");

      // Abort a clear with reset at idx==5
      fill_all();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("abort_busy_pre", clr_busy, 1'b1);
      rst_n = 1'b0; rd_en = 1'b1; rd_addr1 = 4'd12; rd_addr2 = 4'd14;
      wr_en = 1'b1; wr_addr = 4'd12; wr_data = 8'h44;
      tick();
      rst_n = 1'b1; idle_inputs();
      check("abort_busy", clr_busy, 1'b0);
      check("abort_rd1", rd_data1, 8'h00);
      check("abort_rd2", rd_data2, 8'h00);
      check("abort_z_rd1", z_rd_data1, 8'h00);
      tick();
      check("abort_busy_stays", clr_busy, 1'b0);
      check_all_cleared("abort");

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule : tb_reg_file_param
